// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with occupancy count, threshold flags and sticky error flags.
//
// Parameters:
//   DEPTH      - entry count (power of two, >= 2)
//   DATA_WIDTH - bits per entry
//   AF_THRESH  - almost_full_o asserts when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  - almost_empty_o asserts when count <= AE_THRESH (0..DEPTH-1)
//
// Ports:
//   clk_i, rst_ni        - clock, synchronous active-low reset
//   wr_en, data_i        - write request and write data
//   rd_en                - read request
//   clr_err_i            - clears overflow_o / underflow_o
//   data_o, rvalid_o     - registered read data, valid for the cycle after an accepted read
//   full_o, empty_o      - occupancy == DEPTH / == 0 (full_o is forced high while in reset)
//   almost_full_o/_empty - threshold flags
//   count_o              - occupancy 0..DEPTH
//   overflow_o           - sticky: write attempted while full
//   underflow_o          - sticky: read attempted while empty
module fifo_sync_flags #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     rd_en,
  input  logic                     clr_err_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     rvalid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] AfLvl = AF_THRESH[PtrW:0];
  localparam logic [PtrW:0] AeLvl = AE_THRESH[PtrW:0];

  // Pointers carry one extra wrap bit above the index.
  logic [PtrW:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]           rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    rvalid_q, rvalid_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic ptr_full, ptr_empty;
  logic wr_acc, rd_acc;

  assign ptr_full  = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) &&
                     (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
  assign ptr_empty = (wr_ptr_q == rd_ptr_q);

  // Holding full high during reset blocks writes in the reset cycle.
  assign full_o         = ptr_full | ~rst_ni;
  assign empty_o        = ptr_empty;
  assign almost_full_o  = (count_q >= AfLvl);
  assign almost_empty_o = (count_q <= AeLvl);
  assign count_o        = count_q;
  assign data_o         = data_q;
  assign rvalid_o       = rvalid_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // Acceptance uses the flags as registered before the edge.
  assign wr_acc = wr_en & ~full_o;
  assign rd_acc = rd_en & ~empty_o;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_d      = data_q;
    rvalid_d    = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q[PtrW-1:0]];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new error in the same cycle takes priority over the clear.
    if (clr_err_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full_o)   overflow_d  = 1'b1;
    if (rd_en && empty_o)  underflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: doc/fifo_sync_flags.md
FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 The block SHALL take parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 8, bits per entry, >= 1.
REQ-003 The block SHALL take parameter AF_THRESH, default DEPTH-2, almost-full level; range 1..DEPTH.
REQ-004 The block SHALL take parameter AE_THRESH, default 2, almost-empty level; range 0..DEPTH-1.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all state on rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit, synchronous active-low reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-008 The block SHALL have port data_i, input, DATA_WIDTH bits, write data.
REQ-009 The block SHALL have port rd_en, input, 1 bit, read request.
REQ-010 The block SHALL have port clr_err_i, input, 1 bit, clears the sticky error flags.
REQ-011 The block SHALL have port data_o, output, DATA_WIDTH bits, registered read data.
REQ-012 The block SHALL have port rvalid_o, output, 1 bit, data_o updated by a read this cycle.
REQ-013 The block SHALL have port full_o, output, 1 bit, count == DEPTH.
REQ-014 The block SHALL have port empty_o, output, 1 bit, count == 0.
REQ-015 The block SHALL have port almost_full_o, output, 1 bit, count >= AF_THRESH.
REQ-016 The block SHALL have port almost_empty_o, output, 1 bit, count <= AE_THRESH.
REQ-017 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits, current occupancy 0..DEPTH.
REQ-018 The block SHALL have port overflow_o, output, 1 bit, sticky: a write was attempted while full.
REQ-019 The block SHALL have port underflow_o, output, 1 bit, sticky: a read was attempted while empty.

Function
REQ-020 A write SHALL be accepted when wr_en=1 and full_o=0; data_i is stored at the write pointer and the write pointer advances by 1, modulo DEPTH.
REQ-021 A read SHALL be accepted when rd_en=1 and empty_o=0; the entry at the read pointer is loaded into data_o on that edge, rvalid_o=1 for exactly that following cycle, and the read pointer advances modulo DEPTH.
REQ-022 Read latency SHALL be one cycle; data_o SHALL hold its last value when no read is accepted.
REQ-023 Pointers SHALL carry one extra wrap bit; full when indices match and wrap bits differ; empty when all bits match; correct for any legal DEPTH.
REQ-024 Acceptance SHALL use the flags as they stand before the edge: when full, a simultaneous read is accepted and the write is rejected; when empty, the write is accepted and the read is rejected.
REQ-025 When both a read and a write are accepted in one cycle, count_o SHALL be unchanged; it increments on write-only and decrements on read-only.
REQ-026 A write written in cycle N SHALL be readable (empty_o=0) from cycle N+1; no fall-through to data_o.
REQ-027 Reads SHALL NOT clear storage; entries are not initialised by reset.
REQ-028 overflow_o SHALL set on the edge after wr_en=1 with full_o=1; underflow_o SHALL set on the edge after rd_en=1 with empty_o=1; rejected requests change no other state.
REQ-029 clr_err_i=1 SHALL clear both error flags at the next edge, except that a set condition in the same cycle wins.
REQ-030 All flags SHALL derive from registered count/pointers with no combinational path from wr_en or rd_en.

Reset
REQ-031 With rst_ni=0 at a rising edge, the block SHALL reset pointers, count_o, data_o, rvalid_o, overflow_o, and underflow_o to 0, giving empty_o=1, almost_empty_o=1, and almost_full_o=0 (for AF_THRESH>=1).
REQ-032 While rst_ni=0, full_o SHALL be forced to 1, blocking writes; it is released in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all contents; wr_en and rd_en in the reset cycle SHALL be ignored.

Verification
REQ-034 Bench SHALL check fill/drain with defaults: write 0x00..0x0F over 16 cycles -> full_o=1, count_o=16, almost_full_o=1 from count 14; 16 reads -> data_o 0x00..0x0F in order, one cycle after each rd_en, rvalid_o per read, then empty_o=1.
REQ-035 Bench SHALL check overflow: on a full FIFO, wr_en with data 0xAA -> overflow_o=1 next cycle and count_o stays 16; later reads never return 0xAA; clr_err_i -> overflow_o=0.
REQ-036 Bench SHALL check underflow: on an empty FIFO, rd_en -> underflow_o=1, rvalid_o=0, data_o unchanged; clr_err_i together with a second empty read -> underflow_o stays 1.
REQ-037 Bench SHALL check simultaneous events: at count 5, read and write together -> count_o stays 5; when full, both together -> read accepted, write rejected, count 15, overflow_o=1; when empty, both together -> count 1, underflow_o=1.
REQ-038 Bench SHALL check wrap: 40 cycles of alternating write/read bursts with DEPTH=4 and DATA_WIDTH=3 -> output order matches a reference queue and count_o always matches it.
REQ-039 Bench SHALL check mid-operation reset: at count 9, rst_ni=0 for one edge with wr_en=1 -> count_o=0, empty_o=1, full_o=1 during reset, and errors cleared.
